sha256_multiblock_core: RTL and testbench

Parametrised successor SHA-256 core: accepts pre-padded message blocks over a ready/valid stream of configurable width and runs any number of 512-bit blocks with hash chaining. Streams the digest out over a ready/valid port of configurable width. Sits between the message packer and the UART transmitter path. Message schedule and compression (one round per cycle) are both internal, so the block is self-contained.

---
 rtl/sha256_pkg.sv | 66 ++++++
 rtl/sha256_round.sv | 38 +++
 rtl/sha256_multiblock_core.sv | 154 +++++++++++++++
 tb/tb_sha256_multiblock_core.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the bitwise round helpers
// used by the multi-block core and its combinational round stage.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, SEND} state_t;

  localparam word_t K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam word_t IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t bsig0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t bsig1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ssig0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t ssig1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // H0 lands in the top 32 bits so the digest can be shifted out MSB first.
  function automatic logic [255:0] iv_flat(input logic m224);
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[255-32*i -: 32] = m224 ? IV224[i] : IV256[i];
    return v;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: optional message-schedule expansion
// followed by the a..h compression step.
module sha256_round
  import sha256_pkg::*;
(
  input  word_t st_in [8],
  input  word_t k_t,
  input  word_t w_t,
  input  word_t w_m2,
  input  word_t w_m7,
  input  word_t w_m15,
  input  word_t w_m16,
  input  logic  expand,
  output word_t st_out [8],
  output word_t w_new
);

  word_t w_use;
  word_t t1;
  word_t t2;

  // Rounds 16..63 use the freshly expanded word instead of the stored slot.
  always_comb begin
    w_new     = ssig1(w_m2) + w_m7 + ssig0(w_m15) + w_m16;
    w_use     = expand ? w_new : w_t;
    t1        = st_in[7] + bsig1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k_t + w_use;
    t2        = bsig0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
    st_out[0] = t1 + t2;
    st_out[1] = st_in[0];
    st_out[2] = st_in[1];
    st_out[3] = st_in[2];
    st_out[4] = st_in[3] + t1;
    st_out[5] = st_in[4];
    st_out[6] = st_in[5];
    st_out[7] = st_in[6];
  end

endmodule

// File: rtl/sha256_multiblock_core.sv
// Multi-block SHA-256 core with stream input packing and digest serializer.
// Define SHA256_CORE_SHA224_EN to add the mode_224 port and SHA-224 support.
module sha256_multiblock_core
  import sha256_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  input  logic                 out_ready,
`ifdef SHA256_CORE_SHA224_EN
  input  logic                 mode_224,
`endif
  output logic                 busy
);

  localparam int BEATS = 512 / IN_WIDTH;
  localparam int BCW   = $clog2(BEATS);
  localparam int SUBW  = $clog2(32 / IN_WIDTH);
  localparam int OCW   = $clog2(256 / OUT_WIDTH);
  localparam logic [OCW-1:0] LAST256 = OCW'(256 / OUT_WIDTH - 1);

  state_t             state, state_nxt;
  logic [BCW-1:0]     bcnt;
  logic [5:0]         tcnt;
  logic [OCW-1:0]     ocnt;
  logic [OCW-1:0]     ocnt_last;
  logic [255:0]       h;
  logic [255:0]       first_iv;
  word_t              st [8];
  word_t              st_nxt [8];
  word_t              w [16];
  word_t              w_new;
  word_t              w_packed;
  logic               last_blk;
  logic               beat_last;
  logic               expand;
  logic [3:0]         word_idx;
  logic [3:0]         t4;

`ifdef SHA256_CORE_SHA224_EN
  localparam logic [OCW-1:0] LAST224 = OCW'(224 / OUT_WIDTH - 1);
  logic mode_q;

  always_ff @(posedge clk) begin
    if (rst) mode_q <= 1'b0;
    else if (state == IDLE && in_valid) mode_q <= mode_224;
  end

  assign first_iv  = iv_flat(mode_224);
  assign ocnt_last = mode_q ? LAST224 : LAST256;
`else
  assign first_iv  = iv_flat(1'b0);
  assign ocnt_last = LAST256;
`endif

  assign in_ready  = (state == IDLE) || (state == LOAD);
  assign busy      = (state != IDLE);
  assign out_valid = (state == SEND);
  assign out_data  = (state == SEND) ? h[255 -: OUT_WIDTH] : '0;
  assign out_last  = (state == SEND) && (ocnt == ocnt_last);

  assign beat_last = (bcnt == BCW'(BEATS - 1));
  assign word_idx  = 4'(bcnt >> SUBW);
  assign w_packed  = (w[word_idx] << IN_WIDTH) | 32'(in_data);
  assign t4        = tcnt[3:0];
  assign expand    = |tcnt[5:4];

  sha256_round u_round (
    .st_in  (st),
    .k_t    (K[tcnt]),
    .w_t    (w[t4]),
    .w_m2   (w[t4 + 4'd14]),
    .w_m7   (w[t4 + 4'd9]),
    .w_m15  (w[t4 + 4'd1]),
    .w_m16  (w[t4]),
    .expand (expand),
    .st_out (st_nxt),
    .w_new  (w_new)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOAD;
      LOAD:    if (in_valid && beat_last) state_nxt = ROUND;
      ROUND:   if (tcnt == 6'd63) state_nxt = UPDATE;
      UPDATE:  state_nxt = last_blk ? SEND : LOAD;
      SEND:    if (out_ready && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beats shift into their word from the right, so the first beat ends up MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      h        <= iv_flat(1'b0);
      bcnt     <= '0;
      tcnt     <= '0;
      ocnt     <= '0;
      last_blk <= 1'b0;
      for (int i = 0; i < 8; i++) st[i] <= '0;
    end else begin
      if (in_ready && in_valid) begin
        w[word_idx] <= w_packed;
        bcnt        <= beat_last ? '0 : bcnt + BCW'(1);
      end
      case (state)
        IDLE: if (in_valid) h <= first_iv;
        LOAD: begin
          if (in_valid && beat_last) begin
            last_blk <= in_last;
            tcnt     <= '0;
            for (int i = 0; i < 8; i++) st[i] <= h[255-32*i -: 32];
          end
        end
        ROUND: begin
          for (int i = 0; i < 8; i++) st[i] <= st_nxt[i];
          if (expand) w[t4] <= w_new;
          tcnt <= tcnt + 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) h[255-32*i -: 32] <= h[255-32*i -: 32] + st[i];
        end
        SEND: begin
          if (out_ready) begin
            if (out_last) begin
              h    <= iv_flat(1'b0);
              ocnt <= '0;
            end else begin
              h    <= h << OUT_WIDTH;
              ocnt <= ocnt + OCW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_multiblock_core.sv
// Scoreboard bench for sha256_multiblock_core: 32-in/8-out and 8-in/32-out instances.
module tb_sha256_multiblock_core;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  localparam logic [31:0] ABC [16] = '{
    32'h61626380, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000018
  };
  localparam logic [31:0] TWO1 [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [31:0] TWO2 [16] = '{
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0
  };
  localparam logic [31:0] ABC_DIG [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };
  localparam logic [31:0] TWO_DIG [8] = '{
    32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1
  };
`ifdef SHA256_CORE_SHA224_EN
  localparam logic [31:0] D224 [8] = '{
    32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
    32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h0
  };
`endif

  logic        clk;
  logic        rst;
  logic        a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_last, a_out_ready, a_busy;
  logic [31:0] a_in_data;
  logic [7:0]  a_out_data;
  logic        b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_last, b_out_ready, b_busy;
  logic [7:0]  b_in_data;
  logic [31:0] b_out_data;
`ifdef SHA256_CORE_SHA224_EN
  logic        a_mode, b_mode;
`endif

  int    n_cmp = 0;
  int    n_bad = 0;
  int    edge_cnt = 0;
  int    arm_a = -1;
  int    arm_b = -1;
  logic  a_prev_valid = 1'b0;
  logic  b_prev_valid = 1'b0;
  beat_t qa [$];
  beat_t qb [$];

  sha256_multiblock_core #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_last(a_in_last),
    .in_ready(a_in_ready), .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(a_out_ready),
`ifdef SHA256_CORE_SHA224_EN
    .mode_224(a_mode),
`endif
    .busy(a_busy)
  );

  sha256_multiblock_core #(.IN_WIDTH(8), .OUT_WIDTH(32)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready),
`ifdef SHA256_CORE_SHA224_EN
    .mode_224(b_mode),
`endif
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h at edge %0d", name, act, expv, edge_cnt);
    end
  endtask

  task automatic failNote(input string name);
    n_cmp++;
    n_bad++;
    $display("[TB] FAIL %s: bound expired at edge %0d", name, edge_cnt);
  endtask

  // Output monitors: compare every presented beat against the queue head, pop on transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && !a_prev_valid && arm_a >= 0) begin
        checkOutput("valid_rise_a", edge_cnt, arm_a);
        arm_a = -1;
      end
      if (a_out_valid) begin
        if (qa.size() == 0) failNote("unexpected_beat_a");
        else begin
          checkOutput("data_a", {24'b0, a_out_data}, qa[0].data);
          checkOutput("last_a", {31'b0, a_out_last}, {31'b0, qa[0].last});
          if (a_out_ready) void'(qa.pop_front());
        end
      end
    end
    a_prev_valid = a_out_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (b_out_valid && !b_prev_valid && arm_b >= 0) begin
        checkOutput("valid_rise_b", edge_cnt, arm_b);
        arm_b = -1;
      end
      if (b_out_valid) begin
        if (qb.size() == 0) failNote("unexpected_beat_b");
        else begin
          checkOutput("data_b", b_out_data, qb[0].data);
          checkOutput("last_b", {31'b0, b_out_last}, {31'b0, qb[0].last});
          if (b_out_ready) void'(qb.pop_front());
        end
      end
    end
    b_prev_valid = b_out_valid;
  end

  task automatic pushDigestA(input logic [31:0] d [8], input int nw);
    beat_t b;
    for (int i = 0; i < nw; i++)
      for (int j = 0; j < 4; j++) begin
        b.data = {24'b0, d[i][31-8*j -: 8]};
        b.last = (i == nw - 1) && (j == 3);
        qa.push_back(b);
      end
  endtask

  task automatic pushDigestB(input logic [31:0] d [8]);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.data = d[i];
      b.last = (i == 7);
      qb.push_back(b);
    end
  endtask

  task automatic sendBeatA(input logic [31:0] d, input logic last, output int rdy_edge, output int acc_edge);
    int n = 0;
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_last  = last;
    while (!a_in_ready && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    rdy_edge = edge_cnt;
    if (!a_in_ready) failNote("in_ready_a");
    @(posedge clk); #2;
    acc_edge   = edge_cnt;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] blk [16], input logic last, output int first_rdy, output int acc_edge);
    int r;
    for (int i = 0; i < 16; i++) begin
      sendBeatA(blk[i], last && (i == 15), r, acc_edge);
      if (i == 0) first_rdy = r;
    end
  endtask

  task automatic sendBlockB(input logic [31:0] blk [16], output int acc_edge);
    int n;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #2;
      end
      b_in_valid = 1'b1;
      b_in_data  = blk[i/4][31-8*(i%4) -: 8];
      b_in_last  = (i == 63);
      n = 0;
      while (!b_in_ready && n < 300) begin
        @(posedge clk); #2;
        n++;
      end
      if (!b_in_ready) failNote("in_ready_b");
      @(posedge clk); #2;
      acc_edge   = edge_cnt;
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
    end
  endtask

  task automatic drainA();
    int n = 0;
    while (qa.size() != 0 && n < 600) begin
      @(posedge clk); #2;
      n++;
    end
    if (qa.size() != 0) failNote("drain_a");
    qa.delete();
    repeat (2) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic drainB();
    int n = 0;
    while (qb.size() != 0 && n < 600) begin
      @(posedge clk); #2;
      n++;
    end
    if (qb.size() != 0) failNote("drain_b");
    qb.delete();
  endtask

  task automatic checkIdleA(input string tag);
    checkOutput({tag, "_in_ready"},  {31'b0, a_in_ready},  32'd1);
    checkOutput({tag, "_out_valid"}, {31'b0, a_out_valid}, 32'd0);
    checkOutput({tag, "_out_data"},  {24'b0, a_out_data},  32'd0);
    checkOutput({tag, "_out_last"},  {31'b0, a_out_last},  32'd0);
    checkOutput({tag, "_busy"},      {31'b0, a_busy},      32'd0);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r1, r2, acc1, acc2, n;
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_out_ready = 1'b1;
`ifdef SHA256_CORE_SHA224_EN
    a_mode = 1'b0; b_mode = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    checkIdleA("reset");
    rst = 1'b0;

    $display("[TB] single block abc");
    pushDigestA(ABC_DIG, 8);
    applyStimulus(ABC, 1'b1, r1, acc1);
    arm_a = acc1 + 65;
    drainA();

    $display("[TB] two-block message");
    pushDigestA(TWO_DIG, 8);
    applyStimulus(TWO1, 1'b0, r1, acc1);
    applyStimulus(TWO2, 1'b1, r2, acc2);
    checkOutput("reopen_edge", r2, acc1 + 65);
    arm_a = acc2 + 65;
    drainA();

    $display("[TB] output backpressure");
    a_out_ready = 1'b0;
    pushDigestA(ABC_DIG, 8);
    applyStimulus(ABC, 1'b1, r1, acc1);
    arm_a = acc1 + 65;
    n = 0;
    while (!a_out_valid && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    if (!a_out_valid) failNote("wait_out_valid");
    a_out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #2;
    end
    a_out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #2;
    end
    a_out_ready = 1'b1;
    drainA();

    $display("[TB] 8-bit input with gaps");
    pushDigestB(ABC_DIG);
    sendBlockB(ABC, acc1);
    arm_b = acc1 + 65;
    drainB();

    $display("[TB] reset mid-round");
    applyStimulus(ABC, 1'b1, r1, acc1);
    repeat (30) begin
      @(posedge clk); #2;
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checkIdleA("midrst");
    pushDigestA(ABC_DIG, 8);
    applyStimulus(ABC, 1'b1, r1, acc1);
    arm_a = acc1 + 65;
    drainA();

`ifdef SHA256_CORE_SHA224_EN
    $display("[TB] SHA-224 abc");
    a_mode = 1'b1;
    pushDigestA(D224, 7);
    applyStimulus(ABC, 1'b1, r1, acc1);
    a_mode = 1'b0;
    drainA();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
